// File: rtl/sobel_window_engine.sv
// sobel_window_engine
// Consumes three column-aligned row taps from the line buffer, builds a 3x3
// window and produces the saturated Sobel magnitude |Gx|+|Gy|. A result is
// tagged valid only when its window lies entirely inside the image. The
// arithmetic pipeline free-runs; only the counters and window follow we_i.

module sobel_window_engine #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [7:0] row0_i,
  input  logic [7:0] row1_i,
  input  logic [7:0] row2_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       frame_done_o
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);

  // Position counters for the pixel currently presented on the taps
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;

  // Window storage: win_reg[r][c], r=0 newest row, c=2 newest column
  logic [7:0] win_reg [3][3];
  logic [7:0] tap     [3];

  // Pipeline flags and datapath registers
  logic              s1_valid_reg;
  logic              s1_last_reg;
  logic              s2_valid_reg;
  logic              s2_last_reg;
  logic              s3_valid_reg;
  logic              s3_last_reg;
  logic signed [10:0] gx_reg;
  logic signed [10:0] gy_reg;
  logic        [10:0] sum_reg;

  // Combinational helpers
  logic              qualify;
  logic              last_pixel;
  logic        [10:0] gx_pos;
  logic        [10:0] gx_neg;
  logic        [10:0] gy_pos;
  logic        [10:0] gy_neg;
  logic signed [10:0] gx_next;
  logic signed [10:0] gy_next;
  logic        [10:0] abs_gx;
  logic        [10:0] abs_gy;
  logic        [7:0]  sat_next;

  assign tap[0] = row0_i;
  assign tap[1] = row1_i;
  assign tap[2] = row2_i;

  // Window qualifies using the counter values of the pixel being sampled
  assign qualify    = (row_reg >= ROW_MIN) && (col_reg >= COL_MIN);
  assign last_pixel = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

  // Advance column/row position on every accepted pixel, wrapping per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (we_i) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
      end else begin
        col_reg <= col_reg + COL_W'(1);
      end
    end
  end

  // One 3-deep shift register per row tap; stale columns at line start are
  // left in place because the qualify rule masks them
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
      // Shift this row's window left and load the newest pixel on we_i
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          win_reg[gi][0] <= '0;
          win_reg[gi][1] <= '0;
          win_reg[gi][2] <= '0;
        end else if (we_i) begin
          win_reg[gi][0] <= win_reg[gi][1];
          win_reg[gi][1] <= win_reg[gi][2];
          win_reg[gi][2] <= tap[gi];
        end
      end
    end
  endgenerate

  // Stage 1 flags: a result is owed only for a qualifying sampled pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= we_i && qualify;
      s1_last_reg  <= we_i && qualify && last_pixel;
    end
  end

  // Weighted column/row sums; each side is at most 4*255 so 11 bits suffice
  always_comb begin
    gx_pos = {3'b000, win_reg[0][2]} + {2'b00, win_reg[1][2], 1'b0} + {3'b000, win_reg[2][2]};
    gx_neg = {3'b000, win_reg[0][0]} + {2'b00, win_reg[1][0], 1'b0} + {3'b000, win_reg[2][0]};
    gy_pos = {3'b000, win_reg[2][0]} + {2'b00, win_reg[2][1], 1'b0} + {3'b000, win_reg[2][2]};
    gy_neg = {3'b000, win_reg[0][0]} + {2'b00, win_reg[0][1], 1'b0} + {3'b000, win_reg[0][2]};
    gx_next = $signed(gx_pos - gx_neg);
    gy_next = $signed(gy_pos - gy_neg);
  end

  // Stage 2: register the signed gradients alongside their flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_reg       <= '0;
      gy_reg       <= '0;
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
    end else begin
      gx_reg       <= gx_next;
      gy_reg       <= gy_next;
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
    end
  end

  // Magnitudes never exceed 1020, so negation cannot overflow 11 bits
  always_comb begin
    abs_gx = gx_reg[10] ? (~gx_reg + 11'd1) : gx_reg;
    abs_gy = gy_reg[10] ? (~gy_reg + 11'd1) : gy_reg;
  end

  // Stage 3: register |Gx|+|Gy| (max 2040, fits 11 bits unsigned)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg      <= '0;
      s3_valid_reg <= 1'b0;
      s3_last_reg  <= 1'b0;
    end else begin
      sum_reg      <= abs_gx + abs_gy;
      s3_valid_reg <= s2_valid_reg;
      s3_last_reg  <= s2_last_reg;
    end
  end

  assign sat_next = (sum_reg > 11'd255) ? 8'd255 : sum_reg[7:0];

  // Stage 4: saturated output; data_o keeps its last result between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o      <= 1'b0;
      data_o       <= '0;
      frame_done_o <= 1'b0;
    end else begin
      valid_o      <= s3_valid_reg;
      frame_done_o <= s3_last_reg;
      if (s3_valid_reg) begin
        data_o <= sat_next;
      end
    end
  end

endmodule

// File: doc/sobel_window_engine.md
Name: sobel_window_engine

Overview:
- Sits directly downstream of the two-line FIFO buffer and consumes its three aligned row taps.
- Builds a 3x3 pixel window, computes the Sobel gradient magnitude |Gx|+|Gy| saturated to 8 bits, and tags outputs valid only where the window lies fully inside the image.
- The result stream feeds the output writer. Frame-end is flagged on the last valid result.

Parameters:
- IMG_WIDTH, 640, pixels per line; must equal the line buffer depth.
- IMG_HEIGHT, 480, lines per frame.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- we_i  input  1  pixel strobe; the three row inputs are valid and aligned in this cycle.
- row0_i  input  8  current-line pixel (newest row, bottom of window).
- row1_i  input  8  same column, previous line.
- row2_i  input  8  same column, two lines earlier (oldest row, top of window).
- valid_o  output  1  data_o holds a valid Sobel result.
- data_o  output  8  saturated gradient magnitude.
- frame_done_o  output  1  one-cycle pulse coincident with the last valid result of a frame.

Behaviour:
- Reset: asynchronous. Clears col/row counters, window registers, valid pipeline, valid_o, data_o and frame_done_o to 0. Reset mid-frame abandons all in-flight results; no valid_o after rst deasserts until a new window qualifies. The next we_i is treated as row 0, col 0.
- Counters:
  - col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1; both advance only on we_i.
  - col wraps to 0 and increments row; row wraps to 0 after the last pixel of the frame.
- Window:
  - Three 3-deep shift registers, one per row tap, shift on we_i only. Column index 0 is the oldest, 2 the newest (the current pixel).
  - No clearing at line start; stale columns are masked by the qualify rule.
- Qualify: the window completed by a we_i is valid iff row >= 2 and col >= 2, using the counter values for that pixel (before increment). This gives (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame.
- Arithmetic (p[r][c], r=0 bottom/newest row, r=2 top/oldest row):
  - Gx = (p0[2] + 2*p1[2] + p2[2]) - (p0[0] + 2*p1[0] + p2[0])
  - Gy = (p2[0] + 2*p2[1] + p2[2]) - (p0[0] + 2*p0[1] + p0[2])
  - Gx, Gy are 11-bit signed, range ±1020. Sum |Gx|+|Gy| is 11-bit unsigned, max 2040. data_o = 255 if sum > 255, else sum[7:0].
- Pipeline timing:
  - Stage 1: window registers plus qualify flag, on the we_i edge of cycle T.
  - Stage 2: Gx/Gy registered.
  - Stage 3: abs and sum registered.
  - Stage 4: saturate into data_o/valid_o.
  - valid_o is high in cycle T+3 for a qualifying pixel sampled in cycle T. The pipeline free-runs every clock and is not stalled by we_i gaps.
- valid_o is a single-cycle pulse per result. Back-to-back we_i gives back-to-back valid_o.
- data_o holds its last value when valid_o=0; it is not re-zeroed.
- frame_done_o: asserted in the same cycle as valid_o for the pixel at row=IMG_HEIGHT-1, col=IMG_WIDTH-1; otherwise 0.
- Consecutive frames with no gap are supported. Counters wrap and frame N+1 rows 0-1 produce no results.

Test Plan:
- Setup for all cases: IMG_WIDTH=8, IMG_HEIGHT=6, driven through the real line buffer. Expect 24 results per frame.
- Flat frame, all pixels 100, we_i continuous -> 24 valid_o pulses, all data_o=0; frame_done_o on the 24th only; first valid_o 3 cycles after pixel (row2,col2).
- Vertical edge, cols 0-3=0 and cols 4-7=255 -> each qualifying row gives 0,0,255,255,0,0 (raw sum 1020 saturated at col 4 and col 5).
- Horizontal ramp, pixel=10*col -> every result 80 (Gx=80, Gy=0). Vertical ramp, pixel=10*row -> every result 80 (Gy=-80).
- Repeat the ramp and edge frames with we_i randomly deasserted about 40% of cycles -> identical data_o sequence and count; each valid_o exactly 3 cycles after its qualifying we_i.
- Assert rst for 2 cycles mid-frame (row 3, col 4), then stream a fresh flat frame -> valid_o=0 and data_o=0 during reset; exactly 24 results and one frame_done_o follow. Two back-to-back frames -> 48 results, 2 frame_done_o pulses.
